// File: rtl/usf_antidiff_recover.sv
// usf_antidiff_recover: folds the N-th difference into the modulo range, then integrates the residual N times to unfold y
// ports: clk, reset (sync active-low), en sample strobe, y modulo sample, diff_in N-th difference,
//        busy/valid handshake, out recovered sample (holds between updates), overrun sticky drop flag
module usf_antidiff_recover #(
   parameter int max_order   = 3,
   parameter int lambda_log2 = 10,
   parameter int acc_width   = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic signed [15:0]          y,
   input  logic signed [15:0]          diff_in,
   output logic                        busy,
   output logic                        valid,
   output logic signed [acc_width-1:0] out,
   output logic                        overrun
);
   localparam int jw = max_order > 1 ? $clog2(max_order) : 1;
   localparam logic [1:0] s_idle = 2'd0, s_fold = 2'd1, s_acc = 2'd2, s_done = 2'd3;
   localparam logic [acc_width-1:0] lam = acc_width'(1) << lambda_log2;
   localparam logic [acc_width-1:0] mask = (acc_width'(1) << (lambda_log2 + 1)) - acc_width'(1);
   localparam logic [jw-1:0] last = jw'(max_order - 1);
   logic [1:0] state;
   logic [jw-1:0] j;
   logic signed [15:0] y_r;
   logic signed [acc_width-1:0] d_r, v, eps, acc_sum;
   logic [acc_width-1:0] folded;
   // sized to a power of two so the stage index never points outside the array
   logic signed [acc_width-1:0] a [2**jw];
   always_comb begin
      folded = ((d_r + lam) & mask) - lam;
      eps = folded - d_r;
      acc_sum = a[j] + v;
   end
   assign busy = state != s_idle;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= s_idle;
         valid <= 1'b0;
         out <= '0;
         overrun <= 1'b0;
         j <= '0;
         v <= '0;
         y_r <= '0;
         d_r <= '0;
         for (int i = 0; i < 2**jw; i++) a[i] <= '0;
      end else begin
         valid <= 1'b0;
         if (en && state != s_idle) overrun <= 1'b1;
         case (state)
            s_idle: if (en) begin
               y_r <= y;
               d_r <= acc_width'(diff_in);
               j <= '0;
               state <= s_fold;
            end
            s_fold: begin
               v <= eps;
               state <= s_acc;
            end
            s_acc: begin
               a[j] <= acc_sum;
               v <= acc_sum;
               j <= j + 1'b1;
               // out/valid are registered on the final stage so they are visible during the DONE cycle
               if (j == last) begin
                  out <= acc_width'(y_r) + acc_sum;
                  valid <= 1'b1;
                  state <= s_done;
               end
            end
            default: state <= s_idle;
         endcase
      end
   end
endmodule

// File: tb/tb_usf_antidiff_recover.sv
// tb_usf_antidiff_recover: self-checking bench for usf_antidiff_recover at orders 1 and 3
module tb_usf_antidiff_recover;
   logic clk, rst_n, en1, en3;
   logic signed [15:0] yv, dv;
   logic busy1, valid1, overrun1, busy3, valid3, overrun3;
   logic signed [31:0] out1, out3;
   int n_cmp = 0, n_bad = 0;

   typedef struct {
      logic signed [15:0] y;
      logic signed [15:0] d;
      int exp;
   } vec_t;

   usf_antidiff_recover #(.max_order(1)) dut1 (
      .clk(clk), .reset(rst_n), .en(en1), .y(yv), .diff_in(dv),
      .busy(busy1), .valid(valid1), .out(out1), .overrun(overrun1)
   );
   usf_antidiff_recover #(.max_order(3)) dut3 (
      .clk(clk), .reset(rst_n), .en(en3), .y(yv), .diff_in(dv),
      .busy(busy3), .valid(valid3), .out(out3), .overrun(overrun3)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 0;
      en1 = 0;
      en3 = 0;
      yv = 0;
      dv = 0;
      repeat (3) step();
      rst_n = 1;
   endtask

   task automatic send(input int n, input logic signed [15:0] yy, input logic signed [15:0] dd,
                       input logic signed [63:0] exp, input string nm);
      int lat;
      yv = yy;
      dv = dd;
      if (n == 1) en1 = 1;
      else en3 = 1;
      step();
      en1 = 0;
      en3 = 0;
      lat = 1;
      while (!(n == 1 ? valid1 : valid3) && lat < 20) begin
         step();
         lat++;
      end
      check({nm, " latency"}, lat, n + 2);
      check(nm, n == 1 ? out1 : out3, exp);
      step();
   endtask

   initial begin
      vec_t tbl[4];
      int ma[3];
      int pulses, r, e;
      logic signed [15:0] ry, rd;
      tbl[0] = '{0, 16'sd1023, 0};
      tbl[1] = '{0, 16'sd1024, -2048};
      tbl[2] = '{0, -16'sd1024, 0};
      tbl[3] = '{0, -16'sd1025, 2048};

      rst_n = 0;
      en1 = 0;
      en3 = 1;
      yv = 5;
      dv = 2048;
      repeat (3) begin
         step();
         check("reset busy", busy3, 0);
         check("reset valid", valid3, 0);
         check("reset out", out3, 0);
         check("reset overrun", overrun3, 0);
      end
      en3 = 0;
      yv = 0;
      dv = 0;
      rst_n = 1;
      en3 = 1;
      step();
      en3 = 0;
      for (int c = 1; c <= 6; c++) begin
         check($sformatf("idle busy c%0d", c), busy3, c <= 5);
         check($sformatf("idle valid c%0d", c), valid3, c == 5);
         if (c == 5) check("idle out", out3, 0);
         step();
      end

      do_reset();
      send(1, 100, 1500, -1948, "order1 fold");
      send(1, 100, 0, -1948, "order1 hold");

      for (int i = 0; i < 4; i++) begin
         do_reset();
         send(1, tbl[i].y, tbl[i].d, tbl[i].exp, $sformatf("boundary d=%0d", tbl[i].d));
      end

      do_reset();
      send(3, 0, 2048, -2048, "impulse 1");
      repeat (3) step();
      send(3, 0, 0, -6144, "impulse 2");
      repeat (3) step();
      send(3, 0, 0, -12288, "impulse 3");

      do_reset();
      dv = 2048;
      en3 = 1;
      step();
      en3 = 0;
      step();
      step();
      en3 = 1;
      dv = 1000;
      step();
      en3 = 0;
      pulses = 0;
      repeat (12) begin
         if (valid3) pulses++;
         step();
      end
      check("overrun pulses", pulses, 1);
      check("overrun flag", overrun3, 1);
      check("overrun out", out3, -2048);
      send(3, 0, 0, -6144, "overrun follow");
      check("overrun sticky", overrun3, 1);

      do_reset();
      dv = 2048;
      en3 = 1;
      step();
      en3 = 0;
      step();
      step();
      rst_n = 0;
      step();
      rst_n = 1;
      check("midreset busy", busy3, 0);
      check("midreset out", out3, 0);
      pulses = 0;
      repeat (8) begin
         if (valid3) pulses++;
         step();
      end
      check("midreset pulses", pulses, 0);
      send(3, 0, 0, 0, "midreset follow");

      do_reset();
      ma = '{0, 0, 0};
      for (int k = 0; k < 40; k++) begin
         ry = 16'($urandom);
         rd = 16'($urandom);
         r = (int'(rd) + 1024) % 2048;
         if (r < 0) r += 2048;
         e = (r - 1024) - int'(rd);
         ma[0] += e;
         ma[1] += ma[0];
         ma[2] += ma[1];
         send(3, ry, rd, int'(ry) + ma[2], $sformatf("random %0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/usf_antidiff_recover.md
# usf_antidiff_recover

Recovery back-end for the unlimited-sampling path. It sits directly downstream of the multi-order difference operator and consumes its highest-order output together with the aligned modulo sample. For each accepted sample it folds the N-th difference into the centered modulo range to extract the folding residual. It then integrates that residual N times and adds it to the modulo sample, producing the unfolded signal. Processing is iterative: one accumulator stage per clock, sequenced by a small FSM with busy/valid handshake.

## Interface
- `max_order`, default 3: difference order N (1..8); number of anti-difference stages.
- `lambda_log2`, default 10: λ = 2^lambda_log2, the modulo threshold; legal range 1..14.
- `acc_width`, default 32: width of accumulators and `out`, two's complement.

- `clk`  in  1: single clock; all state changes on rising edge.
- `reset`  in  1: synchronous, active-low; sampled on `clk` rising edge.
- `en`  in  1: one-cycle sample strobe, same strobe that advances the upstream difference operator.
- `y`  in  16 signed: modulo sample aligned with `diff_in`; upstream guarantees the alignment.
- `diff_in`  in  16 signed: N-th order backward difference of `y`.
- `busy`  out  1: high while a sample is being processed.
- `valid`  out  1: one-cycle pulse when `out` is updated.
- `out`  out  acc_width signed: recovered sample; holds between updates.
- `overrun`  out  1: sticky; set when `en` arrives while busy.

## Operation
- FSM states: IDLE, FOLD, ACC, DONE.
- **IDLE:** on `en`=1, register `y` and `diff_in` (sign-extended to acc_width), set stage index j=1, go to FOLD.
- **FOLD:** compute d = registered `diff_in`.
  - M(d) = (low lambda_log2+1 bits of (d+λ), unsigned) − λ, giving a result in [−λ, λ).
  - ε = M(d) − d. ε is always an exact multiple of 2λ.
  - Set v = ε and go to ACC.
- **ACC:** one stage per cycle.
  - a_j ← a_j + v, then v ← new a_j, then j ← j+1.
  - After stage j = N, go to DONE.
- **DONE:** out ← sign-extended registered y + v (equal to a_N). Pulse `valid` and go to IDLE.
- Accumulators a_1..a_N persist across samples; they are the N-fold running sum of ε.
- No rounding is applied, because all accumulator values are exact multiples of 2λ.
- Arithmetic wraps at acc_width; there is no saturation.
- `en` while not in IDLE: the sample is dropped, `overrun` is set, and no state is disturbed.
- `overrun` clears only on reset.

## Timing
- `en` is sampled in IDLE at cycle 0.
- FOLD occupies cycle 1 and ACC occupies cycles 2..N+1.
- DONE registers `out` and `valid`; both are visible in cycle N+2.
- Latency from `en` to `valid` is N+2 cycles, which is 5 for N=3.
- `busy` is high in cycles 1..N+2. A new `en` is accepted from cycle N+3 onward.
- Minimum sample spacing is N+3 cycles. With the 10-cycle strobe used upstream this supports N ≤ 7.
- `valid` is high for exactly one cycle per accepted sample.
- Reset (`reset`=0 at a rising edge), including mid-operation:
  - state ← IDLE;
  - all a_j ← 0;
  - `out` ← 0, `valid` ← 0, `busy` ← 0, `overrun` ← 0;
  - any in-flight sample is discarded.
- `en` coincident with reset is ignored.
- Boundary (λ=1024):
  - d=1023 gives M=1023, ε=0.
  - d=1024 gives M=−1024, ε=−2048.
  - d=−1024 gives M=−1024, ε=0.
  - d=−1025 gives M=1023, ε=2048.

## Test plan
- **Reset/idle, default params:** hold `reset`=0 for 3 cycles, then release with `y`=0 and `diff_in`=0 strobed.
  - During reset, all outputs are 0.
  - After the strobe, `valid` pulses at cycle 5 with `out`=0, and `busy` is high for exactly cycles 1..5.
- **Single-stage fold, max_order=1, λ=1024:** strobe `y`=100, `diff_in`=1500.
  - ε=−2048, so `out`=−1948.
  - A second strobe with `y`=100, `diff_in`=0 gives `out`=−1948 (a_1 holds).
- **Range boundaries, max_order=1:** four fresh-reset runs with `y`=0 and `diff_in`=1023, 1024, −1024, −1025.
  - `out` = 0, −2048, 0, 2048 respectively.
- **Third-order impulse, max_order=3, λ=1024:** strobe `diff_in`=2048 then `diff_in`=0 twice, with `y`=0 throughout and strobes 10 cycles apart.
  - `out` = −2048, −6144, −12288.
- **Overrun:** with max_order=3, strobe `en`, then strobe again at cycle 3.
  - `overrun` goes to 1 and stays 1.
  - Only one `valid` pulse occurs, and the accumulators reflect only the first sample.
- **Reset mid-operation:** assert `reset`=0 at cycle 3 of processing `diff_in`=2048.
  - No `valid` pulse; `busy`=0 and `out`=0 next cycle.
  - A following strobe with `diff_in`=0 gives `out`=0, confirming the accumulators were cleared.
